// File: rtl/seg7_pkg.sv
// Shared definitions for the six-digit multiplexed seven-segment scanner:
// digit count, index type, segment patterns and separator-dot placement.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  // Segment order {g,f,e,d,c,b,a}, active-high; codes 10..15 are blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  // Dots after the hours units and minutes units digits (hh.mm.ss).
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder driven by the shared pattern table.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seg7_scan.sv
// Six-digit time-multiplexed display driver: prescaled digit scan, per-frame
// input snapshot, dead time at each slot start, leading-zero blanking, dots.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_2,
  input  logic [3:0] min_1,
  input  logic [3:0] min_2,
  input  logic [3:0] hour_1,
  input  logic [3:0] hour_2,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_END = CNT_W'(DEAD);
  localparam digit_idx_t        IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  logic [3:0]       snap [NUM_DIGITS];
  logic             frame_start;

  logic [3:0]       digit_p0;
  logic [6:0]       pat_p0;
  logic [5:0]       en_p0;
  logic             lit_p0;
  logic             lz_p0;
  logic [5:0]       an_p0;
  logic [6:0]       seg_p0;
  logic             dp_p0;

  logic [5:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Loaded during the blank head of slot 0, so a whole frame shows one time value.
  assign frame_start = (idx == '0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
    end else if (frame_start) begin
      snap[0] <= sec_1;
      snap[1] <= sec_2;
      snap[2] <= min_1;
      snap[3] <= min_2;
      snap[4] <= hour_1;
      snap[5] <= hour_2;
    end
  end

  // Stage p0: select and decode the current digit, apply dead time and blanking.
  always_comb begin
    digit_p0 = '0;
    case (idx)
      3'd0:    digit_p0 = snap[0];
      3'd1:    digit_p0 = snap[1];
      3'd2:    digit_p0 = snap[2];
      3'd3:    digit_p0 = snap[3];
      3'd4:    digit_p0 = snap[4];
      3'd5:    digit_p0 = snap[5];
      default: digit_p0 = '0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_p0),
    .seg (pat_p0)
  );

  assign en_p0  = 6'b000001 << idx;
  assign lit_p0 = (cnt >= DEAD_END);
  assign lz_p0  = (BLANK_LZ != 0) && (idx == IDX_LAST) && (snap[5] == 4'd0);

  // The enable still asserts for a blanked leading zero to keep slot timing uniform.
  assign an_p0  = lit_p0 ? ~en_p0 : 6'b111111;
  assign seg_p0 = (lit_p0 && !lz_p0) ? pat_p0 : 7'h00;
  assign dp_p0  = lit_p0 && !lz_p0 && |(en_p0 & DP_MASK);

  // Stage p1: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= 6'b111111;
      seg_p1 <= 7'h00;
      dp_p1  <= 1'b0;
    end else begin
      an_p1  <= an_p0;
      seg_p1 <= seg_p0;
      dp_p1  <= dp_p0;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: first frame after reset, frame order, snapshot
// behaviour, leading-zero/invalid codes, asynchronous reset and one-hot enables.
module tb_seg7_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] sec_1, sec_2, min_1, min_2, hour_1, hour_2;

  logic [6:0] seg, seg_nl, seg4;
  logic       dp, dp_nl, dp4;
  logic [5:0] an, an_nl, an4;

  int total;
  int bad;
  int edge_n;

  logic [6:0] seg_exp    [6];
  logic [6:0] seg_exp_nl [6];
  logic [5:0] an_tab     [6];
  logic [5:0] dp_tab;

  seg7_scan #(.SCAN_DIV(8), .DEAD(2), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2),
    .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan #(.SCAN_DIV(8), .DEAD(2), .BLANK_LZ(0)) dut_nl (
    .clk(clk), .rst_n(rst_n),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2),
    .seg(seg_nl), .dp(dp_nl), .an(an_nl)
  );

  seg7_scan #(.SCAN_DIV(4), .DEAD(1), .BLANK_LZ(1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2),
    .seg(seg4), .dp(dp4), .an(an4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Output at edge e reflects frame cycle e-1: slot (e-1)/8, slot cycle (e-1)%8.
  task automatic check_now();
    int c;
    int s;
    int k;
    c = (edge_n - 1) % 48;
    s = c / 8;
    k = c % 8;
    if (k < 2) begin
      chk("dead_an", an, 6'h3F);
      chk("dead_seg", seg, 7'h00);
      chk("dead_dp", dp, 1'b0);
      chk("dead_an_nl", an_nl, 6'h3F);
    end else begin
      chk("lit_an", an, an_tab[s]);
      chk("lit_seg", seg, seg_exp[s]);
      chk("lit_dp", dp, dp_tab[s]);
      chk("lit_seg_nl", seg_nl, seg_exp_nl[s]);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    an_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    dp_tab = 6'b010100;

    rst_n  = 1'b0;
    sec_1  = 4'd6; sec_2  = 4'd5;
    min_1  = 4'd4; min_2  = 4'd3;
    hour_1 = 4'd2; hour_2 = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 6'h3F);
    chk("rst_seg", seg, 7'h00);
    chk("rst_dp", dp, 1'b0);
    chk("rst_an4", an4, 6'h3F);

    // Frame 1: 12:34:56, sec_1 changes to 7 during slot 3.
    rst_n = 1'b1;
    seg_exp    = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    seg_exp_nl = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int i = 0; i < 48; i++) begin
      step();
      check_now();
      if (edge_n == 26) sec_1 = 4'd7;
    end

    // Frame 2: new sec_1 appears; hour_2=0 and min_1=B arrive mid-frame.
    seg_exp[0]    = 7'h07;
    seg_exp_nl[0] = 7'h07;
    for (int i = 0; i < 48; i++) begin
      step();
      check_now();
      if (edge_n == 60) begin
        hour_2 = 4'd0;
        min_1  = 4'hB;
      end
    end

    // Frame 3: invalid code blanks slot 2 (dot stays), leading zero blanks slot 5.
    seg_exp[2]    = 7'h00;
    seg_exp[5]    = 7'h00;
    seg_exp_nl[2] = 7'h00;
    seg_exp_nl[5] = 7'h3F;
    dp_tab        = 6'b010100;
    for (int i = 0; i < 37; i++) begin
      step();
      check_now();
    end

    // Now in slot 4, slot cycle 5: reset without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 6'h3F);
    chk("async_seg", seg, 7'h00);
    chk("async_dp", dp, 1'b0);
    chk("async_an_nl", an_nl, 6'h3F);
    sec_1 = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    seg_exp[0]    = 7'h6F;
    seg_exp_nl[0] = 7'h6F;
    for (int i = 0; i < 16; i++) begin
      step();
      check_now();
    end

    // Random inputs on the SCAN_DIV=4, DEAD=1 instance.
    for (int i = 0; i < 10000; i++) begin
      if (i % 5 == 0) begin
        sec_1  = 4'($urandom); sec_2  = 4'($urandom);
        min_1  = 4'($urandom); min_2  = 4'($urandom);
        hour_1 = 4'($urandom); hour_2 = 4'($urandom);
      end
      @(negedge clk);
      chk("onehot_an", ((an4 == 6'h3F) || ($countones(~an4) == 1)) ? 1 : 0, 1);
      chk("blank_seg", ((an4 == 6'h3F) && (seg4 != 7'h00)) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed six-digit seven-segment display driver that sits directly downstream of `digitial_data`. It consumes that block's six BCD digit outputs (`sec_1` … `hour_2`) and drives one shared segment bus plus six digit enables. Digits are shown one at a time at a prescaled scan rate, with a per-frame snapshot to prevent tearing, dead time against ghosting, hour leading-zero blanking and separator dots.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range 4..2^20.
- `DEAD`, default 2: blanking cycles at the start of each slot; legal range 1..`SCAN_DIV`-2.
- `BLANK_LZ`, default 1: 1 = blank `hour_2` when it is 0.
- `clk` input, 1: single system clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `sec_1` input, 4: seconds units, BCD.
- `sec_2` input, 4: seconds tens, BCD.
- `min_1` input, 4: minutes units, BCD.
- `min_2` input, 4: minutes tens, BCD.
- `hour_1` input, 4: hours units, BCD.
- `hour_2` input, 4: hours tens, BCD.
- `seg` output, 7: segments {g,f,e,d,c,b,a}, active-high.
- `dp` output, 1: decimal point, active-high.
- `an` output, 6: digit enables, active-low. Bit k enables digit k.
- Digit order: 0 = `sec_1`, 1 = `sec_2`, 2 = `min_1`, 3 = `min_2`, 4 = `hour_1`, 5 = `hour_2`.

## Operation
- Prescaler `cnt` counts 0..`SCAN_DIV`-1 and wraps.
- Digit index `idx` (0..5) advances on the cycle where `cnt`=`SCAN_DIV`-1. After 5 it wraps to 0.
- Snapshot: on the edge that ends a cycle with `idx`=0 and `cnt`=0, all six inputs load into 24 snapshot registers.
  - This includes the first cycle after reset release.
  - Inputs that change mid-frame have no effect until the next frame.
- Output registers update every cycle from (`idx`, `cnt`, snapshot):
  - `an`: all ones when `cnt` < `DEAD`. Otherwise only bit `idx` is low.
  - `seg`: decode of snapshot digit `idx`.
    - 0..9 use standard patterns, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F.
    - Codes 10..15 decode to 7'h00 (blank, not an error).
  - `seg` is forced to 7'h00 when `cnt` < `DEAD`.
  - Leading-zero blank: when `BLANK_LZ`=1, `idx`=5 and snapshot `hour_2`=0, then `seg`=0 and `dp`=0 for the slot. `an[5]` still asserts, so timing stays uniform.
  - `dp`=1 during the lit part of slots 2 and 4 (hh.mm.ss separators). Otherwise 0.
- Only one `an` bit is ever low. No two digits are ever enabled in the same cycle.

## Timing
- Reset values: `an`=6'b111111, `seg`=7'h00, `dp`=0, `cnt`=0, `idx`=0, snapshot=all zero.
- Output latency is 1 cycle: the outputs reflect the previous cycle's `cnt`/`idx`.
- Because `DEAD`≥1, the snapshot load (frame cycle 0) always precedes the first lit cycle of digit 0.
- Digit k is lit for `SCAN_DIV`-`DEAD` cycles per frame. Frame period is 6·`SCAN_DIV` cycles.
- First lit output after reset release appears on clock edge `DEAD`+1 (counted from the first edge after release).
- Reset asserted mid-slot: all outputs return to reset values immediately (asynchronous). The scan restarts at digit 0 with a fresh snapshot.
- Wrap 5→0 and snapshot load coincide with no dropped or duplicated cycle. Slot 5 is exactly `SCAN_DIV` cycles long.

## Structure
- Shared package `seg7_pkg`:
  - `NUM_DIGITS`=6.
  - Digit-index typedef (3 bits).
  - The 16-entry segment pattern constant.
  - `DP_MASK`=6'b010100.
- Sub-module `bcd_to_seg7`: combinational 4-bit→7-bit decoder using the package table. Instantiated once, on the muxed snapshot digit.
- Top-level: prescaler, index counter, snapshot bank, output registers.

## Test plan
All scenarios use `SCAN_DIV`=8, `DEAD`=2 unless stated.
- **Reset and first frame.** Hold `rst_n`=0 with inputs 12:34:56, then release. Required: `an`=111111 and `seg`=0 for 2 cycles. Then `an`=111110 and `seg`=7'h7D (6) for 6 cycles. Then digit 1 shows 7'h6D (5).
- **Full frame order.** Inputs 12:34:56. Required:
  - `seg` sequence across slots 0..5 is 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06.
  - `dp`=1 only in slots 2 and 4.
  - Next frame starts exactly 48 cycles after the previous one.
- **Tear-free snapshot.** Change `sec_1` from 6 to 7 during slot 3. Required: the current frame's slots are unchanged. Slot 0 of the next frame shows 7'h07.
- **Leading zero and invalid code.** Inputs `hour_2`=0, `min_1`=4'hB.
  - With `BLANK_LZ`=1: slot 5 has `seg`=0 while `an[5]`=0. Slot 2 has `seg`=0 with `dp`=1.
  - With `BLANK_LZ`=0: slot 5 shows 7'h3F.
- **Reset mid-operation.** Assert `rst_n` during slot 4, cycle 5. Required: outputs go to reset values within the same cycle, with no clock edge needed. After release, the scan restarts at slot 0.
- **One-hot enable invariant.** Random inputs, `SCAN_DIV`=4, `DEAD`=1, 10000 cycles. Required: `an` is always either all ones or exactly one zero bit, and `seg`=0 whenever `an`=111111.
